// File: rtl/i2c_target_regs.sv
// I2C target with a register-pointer front end: START/STOP decode, 7-bit address
// match, pointer load, auto-incrementing burst writes and ACK-driven burst reads.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;

    // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
    // NOTE: every flop in a clocked block is assigned with <=, so all registers see
    // pre-edge values and the simulated order of statements cannot change behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & sda_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_q & sda_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;

            // Pointer advances in the clk after each access strobe; 8-bit wrap is natural.
            if (reg_wr || reg_rd)
                reg_addr <= reg_addr + 8'd1;

            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= S_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == DEV_ADDR) begin
                                state  <= S_ADDR_ACK;
                                rw     <= shift[0];
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                            end else begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                reg_rd <= 1'b1;
                                state  <= S_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= S_PTR;
                            end
                        end
                    end
                    S_PTR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            reg_addr <= shift;
                            sda_oe   <= 1'b1;
                            bit_cnt  <= 4'd0;
                            state    <= S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            reg_wdata <= shift;
                            reg_wr    <= 1'b1;
                            sda_oe    <= 1'b1;
                            bit_cnt   <= 4'd0;
                            state     <= S_WDATA_ACK;
                        end
                    end
                    S_RDATA: begin
                        // reg_rdata is valid alongside reg_rd, so capture it in that clk.
                        if (reg_rd) begin
                            shift   <= reg_rdata;
                            sda_oe  <= ~reg_rdata[7];
                            bit_cnt <= 4'd0;
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= S_RDATA_ACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s)
                                state <= S_IGNORE;
                            else
                                bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            reg_rd  <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= S_RDATA;
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) in the DUT, at the far end of the bench's open-drain sclk/sdata bus model.
- Decodes START, STOP and repeated START, and matches a 7-bit device address.
- Presents an 8-bit register-pointer read/write interface to the on-chip register file, e.g. ADC result and control registers.
- Drives SDA only as an open-drain pull-down enable; SCL is input-only, with no clock stretching.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit target address this block responds to.
- SYNC_STAGES, 2, number of synchronizer flops on scl_i and sda_i (minimum 2).

Ports:
- clk  in  1  chip clock.
- reset  in  1  synchronous, active-high reset.
- scl_i  in  1  resolved SCL line level (asynchronous).
- sda_i  in  1  resolved SDA line level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release the line (pulled high on the bus).
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  write data; valid while reg_wr = 1.
- reg_wr  out  1  one-clk write strobe.
- reg_rd  out  1  one-clk read strobe; the register file returns reg_rdata in the same cycle.
- reg_rdata  in  8  read data from the register file.
- busy  out  1  1 from an address-matched START until STOP or return to IDLE.

Behaviour:
- Interface: one clock, clk. Reset is named reset and is synchronous, active-high.
- Reset values: sda_oe = 0, reg_wr = 0, reg_rd = 0, busy = 0, reg_addr = 0x00, state IDLE, bit counter 0.
- Synchronization: scl_i and sda_i pass through SYNC_STAGES flops. Edges are detected on the synced values.
- Conditions:
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
- Bit timing:
  - Data is sampled on the synced SCL rising edge.
  - sda_oe changes only in the clk after a detected SCL falling edge.
  - Required bus timing: SCL low ≥ 4 clk, SCL high ≥ 4 clk.
- State machine: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - START (from any state, including repeated START) → ADDR, bit count cleared, sda_oe = 0. reg_addr is preserved.
  - STOP (from any state) → IDLE, sda_oe = 0, busy = 0. A partially received byte is discarded with no strobe.
  - ADDR: shift 8 bits, MSB first.
    - Upper 7 bits == DEV_ADDR → ADDR_ACK; sda_oe = 1 for the 9th SCL low/high period.
    - Mismatch → IGNORE; no ACK is driven and no strobes occur until the next START.
  - After ADDR_ACK:
    - R/W = 0 → PTR.
    - R/W = 1 → RDATA. Pulse reg_rd at the ACK-period SCL falling edge, load the shift register from reg_rdata the next clk, then drive the MSB.
  - PTR: 8 bits received → reg_addr = byte; ACK; → WDATA.
  - WDATA: 8 bits received.
    - Pulse reg_wr with reg_wdata = byte at the current reg_addr.
    - ACK.
    - reg_addr increments in the clk after the reg_wr pulse; 0xFF wraps to 0x00.
    - Stay in WDATA for further bytes.
  - RDATA: drive sda_oe = ~bit for each of 8 bits; → RDATA_ACK with SDA released.
  - RDATA_ACK: sample the controller's ACK on the 9th SCL rise. reg_addr increments on every read byte, with the same wrap.
    - ACK (SDA low) → reg_rd for the next byte, → RDATA.
    - NACK → IGNORE, SDA released.
- Simultaneous events:
  - STOP/START take priority over bit sampling.
  - reset overrides everything.
  - reset mid-transfer releases SDA immediately in the next clk.
- At most one of reg_wr and reg_rd is high in any clk.

Test Plan:
- Write 0x54 (addr 0x2A, W), ptr 0x10, data 0xA5, STOP → ACK on all three 9th bits; single reg_wr with reg_addr = 0x10, reg_wdata = 0xA5; reg_addr = 0x11 after; busy falls on STOP.
- Burst write ptr 0xFE, data 0x01, 0x02, 0x03 → reg_wr at addresses 0xFE, 0xFF, 0x00 in order; reg_addr ends at 0x01.
- Address 0x56 (0x2B, W) followed by 2 bytes → sda_oe never asserted, no reg_wr/reg_rd, busy = 0; a following valid transaction works normally.
- Write ptr 0x05, repeated START, 0x55 (R), register file returns ~addr → bytes 0xFA, 0xF9 seen on SDA. Controller ACKs byte 1 and NACKs byte 2 → exactly 2 reg_rd pulses, SDA released after byte 2, STOP → IDLE.
- STOP after 4 bits of a WDATA byte → no reg_wr, reg_addr unchanged, sda_oe = 0.
- reset asserted while sda_oe = 1 during a read bit → sda_oe = 0 the next clk, all outputs at reset values; next START + valid write is ACKed.
